imem_loader: RTL and testbench

- Boot-time controller that fills the instruction memory from an external byte stream, e.g. a UART receiver or debug port.
- Receives a 4-byte word-count header, then assembles little-endian bytes into 32-bit instructions.
- Issues one word-aligned write per instruction into the instruction memory's write port.
- Holds the core in stall until the program is fully loaded.
- Sits between the byte-stream receiver, the instruction memory and the core's stall/reset-release logic.

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master modport is the loader's view; slave is the surrounding system.
interface imem_loader_if #(
    parameter int unsigned N = 14
);
    logic           rx_valid;
    logic [7:0]     rx_data;
    logic           rx_ready;
    logic           imem_we;
    logic [N-1:0]   imem_waddr;
    logic [31:0]    imem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: reads a 4-byte little-endian word count, then streams
// little-endian instruction words into the instruction memory, stalling the core until done.
module imem_loader #(
    parameter int unsigned N       = 14,
    parameter int unsigned TIMEOUT = 1000000,
    parameter int unsigned TO_BITS = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    imem_loader_if.master      bus,
    output logic               core_stall,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [N:0]         words_loaded
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;

    localparam logic [32:0]        MAX_WORDS = 33'd1 << N;
    localparam bit                 TO_EN     = (TIMEOUT != 0);
    localparam logic [TO_BITS-1:0] TO_LAST   = TO_BITS'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_bcnt;
    logic [31:0]        r_hdr;
    logic [TO_BITS-1:0] r_to;
    logic               r_we;
    logic [N-1:0]       r_waddr;
    logic [31:0]        r_wdata;
    logic [N:0]         r_words;

    logic               w_loading;
    logic               w_accept;
    logic               w_last_byte;
    logic               w_timeout;
    logic               w_final;
    logic [31:0]        w_hdr_full;

    assign w_loading   = (r_state == S_HDR) || (r_state == S_DATA);
    assign w_accept    = bus.rx_valid && w_loading;
    assign w_last_byte = (r_bcnt == 2'd3);
    assign w_hdr_full  = {bus.rx_data, r_hdr[31:8]};
    assign w_timeout   = TO_EN && (r_to == TO_LAST);
    assign w_final     = (({{(31-N){1'b0}}, r_words}) + 32'd1) == r_hdr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A byte arriving on the expiry cycle wins: timeout only fires without one.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                if (w_accept && w_last_byte) begin
                    if (w_hdr_full == 32'd0) begin
                        w_next = S_DONE;
                    end else if ({1'b0, w_hdr_full} > MAX_WORDS) begin
                        w_next = S_ERR;
                    end else begin
                        w_next = S_DATA;
                    end
                end else if (!w_accept && w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DATA: begin
                if (w_accept && w_last_byte && w_final) begin
                    w_next = S_DONE;
                end else if (!w_accept && w_timeout) begin
                    w_next = S_ERR;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.rx_ready   = w_loading;
        busy           = w_loading;
        core_stall     = (r_state != S_DONE);
        done           = (r_state == S_DONE);
        err            = (r_state == S_ERR);
        bus.imem_we    = r_we;
        bus.imem_waddr = r_waddr;
        bus.imem_wdata = r_wdata;
        words_loaded   = r_words;
    end

    // imem_wdata doubles as the assembly register; the write address advances
    // on the pulse cycle so it still names the word being written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_hdr   <= '0;
            r_to    <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_words <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_words <= '0;
                        r_bcnt  <= '0;
                        r_to    <= '0;
                    end
                end
                S_HDR: begin
                    if (w_accept) begin
                        r_hdr  <= w_hdr_full;
                        r_bcnt <= r_bcnt + 2'd1;
                        r_to   <= '0;
                        if (w_last_byte) begin
                            r_waddr <= '0;
                        end
                    end else if (TO_EN) begin
                        r_to <= r_to + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_we) begin
                        r_waddr <= r_waddr + 1'b1;
                    end
                    if (w_accept) begin
                        r_wdata[{r_bcnt, 3'b000} +: 8] <= bus.rx_data;
                        r_bcnt <= r_bcnt + 2'd1;
                        r_to   <= '0;
                        if (w_last_byte) begin
                            r_we    <= 1'b1;
                            r_words <= r_words + 1'b1;
                        end
                    end else if (TO_EN) begin
                        r_to <= r_to + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed boot scenarios plus random loads,
// checked against expected write lists derived from the byte stream.
module tb_imem_loader;
    localparam int unsigned N       = 14;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned TO_BITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        core_stall;
    logic        busy;
    logic        done;
    logic        err;
    logic [N:0]  words_loaded;

    imem_loader_if #(.N(N)) ifc ();

    imem_loader #(.N(N), .TIMEOUT(TIMEOUT), .TO_BITS(TO_BITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (ifc),
        .core_stall   (core_stall),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [7:0]  stream[$];
    int unsigned exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_final;
    int unsigned exp_words;
    bit          prev_we;
    logic [31:0] mem [int unsigned];
    logic [31:0] saved;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; every write pulse is matched against the expected write list.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ifc.imem_we !== 1'b0) begin
            chk("we_one_cycle", 64'(prev_we), 64'd0);
            if (exp_addr.size() == 0) begin
                chk("spurious_we", 64'(ifc.imem_we), 64'd0);
            end else begin
                chk("waddr", 64'(ifc.imem_waddr), 64'(exp_addr.pop_front()));
                chk("wdata", 64'(ifc.imem_wdata), 64'(exp_data.pop_front()));
                mem[int'(ifc.imem_waddr)] = ifc.imem_wdata;
                if (exp_addr.size() == 0 && exp_final) begin
                    chk("done_at_last_we", 64'(done), 64'd1);
                    chk("stall_at_last_we", 64'(core_stall), 64'd0);
                    chk("words_at_last_we", 64'(words_loaded), 64'(exp_words));
                end
            end
        end
        prev_we = (ifc.imem_we === 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = b;
        for (int t = 0; t < 16 && !ok; t++) begin
            ok = (ifc.rx_ready === 1'b1);
            tick();
        end
        chk("byte_accepted", 64'(ok), 64'd1);
        ifc.rx_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int unsigned gap, input bit rnd);
        for (int i = lo; i < hi; i++) begin
            repeat (rnd ? $urandom_range(gap, 0) : gap) tick();
            send_byte(stream[i]);
        end
    endtask

    // Header of count w followed by data_bytes random data bytes; the expected
    // writes are the complete words among them, addressed from 0.
    task automatic build(input logic [31:0] w, input int unsigned data_bytes);
        logic [31:0] word;
        bit in_range;
        stream.delete();
        exp_addr.delete();
        exp_data.delete();
        in_range = (w != 32'd0) && ({1'b0, w} <= (33'd1 << N));
        for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
        for (int unsigned i = 0; i < (data_bytes + 3) / 4; i++) begin
            word = $urandom;
            for (int unsigned k = 0; k < 4; k++)
                if (4 * i + k < data_bytes) stream.push_back(word[8*k +: 8]);
            if (in_range && 4 * i + 4 <= data_bytes) begin
                exp_addr.push_back(i);
                exp_data.push_back(word);
            end
        end
        exp_words = exp_addr.size();
        exp_final = in_range && (data_bytes >= 4 * w);
    endtask

    task automatic pulse_start(input bit with_byte);
        start = 1'b1;
        if (with_byte) begin
            ifc.rx_valid = 1'b1;
            ifc.rx_data  = 8'h01;
        end
        tick();
        start = 1'b0;
        ifc.rx_valid = 1'b0;
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_stall"}, 64'(core_stall), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rx_ready"}, 64'(ifc.rx_ready), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'(exp_words));
        chk({tag, "_pending"}, 64'(exp_addr.size()), 64'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_stall"}, 64'(core_stall), 64'd1);
        chk({tag, "_rx_ready"}, 64'(ifc.rx_ready), 64'd0);
        chk({tag, "_we"}, 64'(ifc.imem_we), 64'd0);
        chk({tag, "_waddr"}, 64'(ifc.imem_waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(ifc.imem_wdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d2 [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                                8'h93, 8'h05, 8'h20, 8'h00};
        logic [31:0] w;
        ifc.rx_valid = 1'b0;
        ifc.rx_data  = 8'h00;
        exp_final    = 1'b0;
        exp_words    = 0;
        prev_we      = 1'b0;

        // Reset, then rx_valid while idle must not be accepted.
        rst_n = 1'b0;
        tick();
        tick();
        check_reset("reset");
        rst_n = 1'b1;
        tick();
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            chk("idle_rx_ready", 64'(ifc.rx_ready), 64'd0);
            tick();
        end
        ifc.rx_valid = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);

        // Directed two-word program.
        stream.delete();
        foreach (d2[i]) stream.push_back(d2[i]);
        exp_addr = '{0, 1};
        exp_data = '{32'h00100513, 32'h00200593};
        exp_final = 1'b1;
        exp_words = 2;
        pulse_start(1'b0);
        chk("hdr_busy", 64'(busy), 64'd1);
        send_range(0, stream.size(), 0, 1'b0);
        check_done("two_word");
        tick();
        chk("two_word_we_low", 64'(ifc.imem_we), 64'd0);

        // Zero-length header: DONE immediately, no writes.
        build(32'd0, 0);
        pulse_start(1'b0);
        send_range(0, stream.size(), 0, 1'b0);
        check_done("zero_len");
        tick();

        // Oversize header (2^N + 1): error, no writes.
        build(32'd16385, 0);
        pulse_start(1'b0);
        send_range(0, stream.size(), 0, 1'b0);
        chk("oversize_err", 64'(err), 64'd1);
        chk("oversize_stall", 64'(core_stall), 64'd1);
        chk("oversize_done", 64'(done), 64'd0);
        chk("oversize_busy", 64'(busy), 64'd0);
        repeat (3) tick();

        // Gaps shorter than the timeout still complete.
        build(32'd3, 12);
        pulse_start(1'b0);
        send_range(0, stream.size(), 5, 1'b0);
        check_done("gapped");

        // Stream stops after two data bytes: error exactly TIMEOUT cycles later.
        build(32'd2, 2);
        pulse_start(1'b0);
        send_range(0, stream.size(), 0, 1'b0);
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            tick();
            chk("timeout_early_err", 64'(err), 64'd0);
        end
        tick();
        chk("timeout_err", 64'(err), 64'd1);
        chk("timeout_stall", 64'(core_stall), 64'd1);
        chk("timeout_words", 64'(words_loaded), 64'd0);
        chk("timeout_pending", 64'(exp_addr.size()), 64'd0);

        // start during DATA is ignored.
        build(32'd2, 8);
        pulse_start(1'b0);
        send_range(0, 7, 0, 1'b0);
        pulse_start(1'b0);
        chk("start_in_data_busy", 64'(busy), 64'd1);
        send_range(7, stream.size(), 0, 1'b0);
        check_done("start_in_data");

        // Reset after six data bytes, then a one-word load at address 0.
        build(32'd3, 6);
        pulse_start(1'b0);
        send_range(0, stream.size(), 0, 1'b0);
        chk("midload_first_write", 64'(exp_addr.size()), 64'd0);
        rst_n = 1'b0;
        tick();
        check_reset("midload_reset");
        rst_n = 1'b1;
        tick();
        build(32'd1, 4);
        saved = exp_data[0];
        pulse_start(1'b0);
        send_range(0, stream.size(), 0, 1'b0);
        check_done("after_reset");
        chk("after_reset_mem0", 64'(mem[0]), 64'(saved));

        // Reload from DONE; a byte offered with start must not be consumed.
        build(32'd1, 4);
        saved = exp_data[0];
        pulse_start(1'b1);
        chk("reload_stall", 64'(core_stall), 64'd1);
        chk("reload_done", 64'(done), 64'd0);
        chk("reload_words", 64'(words_loaded), 64'd0);
        chk("reload_busy", 64'(busy), 64'd1);
        send_range(0, stream.size(), 0, 1'b0);
        check_done("reload");
        chk("reload_mem0", 64'(mem[0]), 64'(saved));

        // Random loads with random short gaps.
        for (int r = 0; r < 4; r++) begin
            w = 32'($urandom_range(6, 1));
            build(w, 4 * w);
            pulse_start(1'b0);
            send_range(0, stream.size(), 3, 1'b1);
            check_done("random");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
